// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO in front of the shifter.
// Frames are start, DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_BITS-1:0]        dataTX,
  input  logic                        dataTXValid,
  output logic                        dataTXReady,
  output logic                        serialTX,
  output logic                        activeTX,
  output logic                        doneTX,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [PW:0]   FULL_C     = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [CW-1:0]        cycle_q;
  logic [BW-1:0]        bit_q;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;

  logic [DATA_BITS-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr_q, wrPtr_d;
  logic [PW-1:0]        rdPtr_q, rdPtr_d;
  logic [PW:0]          count_q, count_d;
  logic                 push;
  logic                 pop;
  logic                 bitEnd;
  logic [DATA_BITS-1:0] headWord;

  assign dataTXReady = (count_q != FULL_C);
  assign push        = rstn && dataTXValid && dataTXReady;
  // Pop only uses the registered count, so a word written this cycle is fetched next edge at the earliest.
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign headWord    = fifoMem_q[rdPtr_q];
  assign bitEnd      = (cycle_q == CYC_LAST);

  assign serialTX  = serial_q;
  assign activeTX  = active_q;
  assign doneTX    = done_q;
  assign fifoCount = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= dataTX;
  end

  // The shifter keeps the next data bit in shift_q[0]; serial_q is loaded one period ahead of each boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      cycle_q  <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) cycle_q <= bitEnd ? '0 : cycle_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q  <= headWord;
            parity_q <= (PARITY == 1) ? ~^headWord : ^headWord;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (HAS_PARITY) begin
                serial_q <= parity_q;
                state_q  <= PAR;
              end else begin
                serial_q <= 1'b1;
                state_q  <= STOP;
              end
            end else begin
              bit_q    <= bit_q + BW'(1);
              shift_q  <= shift_q >> 1;
              serial_q <= shift_q[1];
            end
          end
        end
        PAR: begin
          if (bitEnd) begin
            serial_q <= 1'b1;
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (bit_q == STOP_LAST) begin
              bit_q    <= '0;
              active_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of 2, range 2..64.
REQ-006 The design SHALL use one clock and a synchronous, active-low reset; clk and rstn are the only clock and reset ports.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rstn  input  1  synchronous active-low reset.
REQ-009 dataTX  input  DATA_BITS  payload word; bit 0 is transmitted first.
REQ-010 dataTXValid  input  1  write request; a word is accepted on a clk edge where dataTXValid=1 and dataTXReady=1.
REQ-011 dataTXReady  output  1  high when the FIFO is not full.
REQ-012 serialTX  output  1  serial line, registered, idle high.
REQ-013 activeTX  output  1  high from the first start-bit cycle to the last stop-bit cycle, inclusive.
REQ-014 doneTX  output  1  one-cycle pulse after the last stop bit of each frame.
REQ-015 fifoCount  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.

Function
REQ-016 The FIFO SHALL write on accept, pop on frame fetch, and keep order; an accept and a pop in the same cycle SHALL leave fifoCount unchanged.
REQ-017 When the FIFO is full, dataTXValid SHALL be ignored, the word dropped, and FIFO contents unchanged.
REQ-018 A word written to an empty FIFO SHALL NOT be forwarded to the shifter in the same cycle; it SHALL be fetched no earlier than the next edge.
REQ-019 FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE -> START: when the FIFO is non-empty; the head word is popped into the shift register on the same edge.
REQ-020 Each state SHALL hold for exactly CLKS_PER_BIT cycles per bit.
- START drives 0.
- DATA drives DATA_BITS bits, LSB first.
- PAR drives the parity bit; the state is skipped when PARITY=0.
- STOP drives 1 for STOP_BITS bits.
REQ-021 Parity bit:
- odd parity = ~^(payload);
- even parity = ^(payload);
- computed from the word latched at fetch.
REQ-022 Frame length SHALL be exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-023 Frame end:
- at expiry of the final stop-bit period the FSM SHALL return to IDLE;
- doneTX=1 for that single cycle;
- activeTX=0 in the same cycle.
REQ-024 Back-to-back frames: exactly one IDLE cycle (serialTX=1) SHALL separate consecutive frames when the FIFO is non-empty.
REQ-025 Changes on dataTX or dataTXValid SHALL NOT affect a frame already in progress.
REQ-026 The bit counter and the cycle counter SHALL be sized by $clog2 of their maximum value and SHALL wrap to 0 at each bit or state boundary.

Reset
REQ-027 While rstn=0 at a clk edge, the following SHALL hold on the next cycle:
- state=IDLE;
- serialTX=1, activeTX=0, doneTX=0;
- fifoCount=0, dataTXReady=1;
- all counters 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, flush the FIFO, and drive serialTX high on the next cycle; no doneTX pulse is produced.
REQ-029 In the cycle rstn=0, dataTXValid SHALL be ignored.

Verification (CLKS_PER_BIT=87 unless stated)
REQ-030 Defaults (8N1): write 8'h55 once -> after 1 idle cycle, serialTX shows 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each held 87 cycles; activeTX high 870 cycles; doneTX pulses once.
REQ-031 PARITY=1, DATA_BITS=7, STOP_BITS=2: write 7'h03 -> parity bit 1; frame lasts 11*87=957 cycles; line held high for the 2 stop bits.
REQ-032 FIFO_DEPTH=4: write 6 words on consecutive cycles while the first frame is starting ->
- dataTXReady drops at fifoCount=4;
- the excess word is dropped;
- the accepted words are transmitted in order, each separated by exactly 1 idle cycle.
REQ-033 Pulse rstn low 3 cycles at data bit 4 of a frame ->
- serialTX=1 on the next cycle;
- fifoCount=0;
- no doneTX pulse;
- the next write transmits normally.
REQ-034 CLKS_PER_BIT=2, PARITY=2, 9-bit word 9'h1FF -> even parity bit 1; total frame 24 cycles.
REQ-035 Simultaneous write and fetch with fifoCount=1 -> fifoCount stays 1 and the order is preserved.
